axi4_spi_flash_boot_loader: RTL and testbench
=============================================

Name: axi4_spi_flash_boot_loader

Overview:
Boot-time copy sequencer driving the AXI4 read channel of the quad-SPI flash XIP port. On `start` it issues INCR bursts covering a flash byte range. Each returned beat goes to a word-wide scratchpad/RAM write port, and the block reports done/error. It sits between the flash XIP slave and the on-chip instruction memory; it is the only AXI4 read master on that port during boot.

Parameters:
- ADDR_WIDTH, 32, AXI address width and width of src/dst addresses.
- DATA_WIDTH, 32, AXI read data width and memory write width; fixed at 32, arsize = 2.
- ID_WIDTH, 1, AXI ID width; arid is constant 0.
- MAX_BURST, 16, maximum beats per burst, 1..256.
- LEN_WIDTH, 24, width of the byte-length input.

Ports:
- clock  in  1  single clock for all logic and the AXI interface.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to begin a copy; sampled only in IDLE.
- src_addr  in  ADDR_WIDTH  flash byte address; bits [1:0] ignored.
- dst_addr  in  ADDR_WIDTH  memory byte address; bits [1:0] ignored.
- length_bytes  in  LEN_WIDTH  byte count; rounded up to whole words.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at completion.
- error  out  1  sticky status of the last copy; cleared on the next accepted start.
- m_axi_arid  out  ID_WIDTH  constant 0.
- m_axi_araddr  out  ADDR_WIDTH  burst start address.
- m_axi_arlen  out  8  beats−1.
- m_axi_arsize  out  3  constant 3'b010.
- m_axi_arburst  out  2  constant 2'b01 (INCR).
- m_axi_arlock  out  1  constant 0.
- m_axi_arcache  out  4  constant 0.
- m_axi_arprot  out  3  constant 0.
- m_axi_arvalid  out  1  address valid.
- m_axi_arready  in  1  address ready.
- m_axi_rid  in  ID_WIDTH  ignored.
- m_axi_rdata  in  DATA_WIDTH  read data.
- m_axi_rresp  in  2  response; nonzero is an error.
- m_axi_rlast  in  1  last beat.
- m_axi_rvalid  in  1  data valid.
- m_axi_rready  out  1  data ready.
- mem_wen  out  1  write strobe.
- mem_addr  out  ADDR_WIDTH  word-aligned write byte address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_ready  in  1  memory accepts the write this cycle.

Behaviour:
- Reset values: busy=0, done=0, error=0, arvalid=0, rready=0, mem_wen=0; araddr, arlen and mem_addr are 0. The state is IDLE.
- Reset mid-operation returns to IDLE immediately with no drain. The flash slave shares this reset.
- States:
  - IDLE→INIT on `start`.
  - INIT→DONE if words==0, else →ADDR.
  - ADDR→DATA on arvalid&&arready.
  - DATA→ADDR after the last beat if words remain and no error.
  - DATA→DONE after the last beat otherwise.
  - DONE→IDLE after 1 cycle, with done=1 in that cycle.
- `start` while busy is ignored; operands are latched on acceptance.
- words = ceil(length_bytes/4). The remaining-word counter is LEN_WIDTH−1 bits.
- Burst beats = min(remaining, MAX_BURST, (4096 − araddr[11:0])/4). A burst never crosses a 4 KB boundary. arlen = beats−1, computed in INIT/DATA and registered before arvalid rises.
- arvalid holds with stable araddr/arlen until arready. Only one burst is outstanding at a time.
- In DATA:
  - rready = mem_ready (combinational).
  - mem_wen = rvalid. mem_wdata = rdata. mem_addr = current destination.
  - A beat completes on rvalid&&rready. Each completed beat advances the destination by 4, advances the source by 4, and decrements remaining.
- Error conditions, each setting the sticky error:
  - rresp≠0 on any beat.
  - rlast on a beat other than the expected final beat.
  - rlast missing on the expected final beat.
- On error, the beat is still written to memory and the current burst drains to its expected beat count. Then DONE; no further bursts are issued.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. No overflow detection.
- Latency: start → arvalid in 2 cycles (IDLE→INIT→ADDR). The last accepted beat → done 1 cycle later.

Test Plan:
- src=0x0000_0000, dst=0x8000_0000, len=64, MAX_BURST=16, slave returns i*4+1 with arready/rvalid always high → one burst with arlen=15. Memory gets 16 writes at 0x8000_0000..0x8000_003C with matching data. done pulses once; error=0.
- src=0x0000_0FF0, len=32 → two bursts: addr 0xFF0 arlen=3, then addr 0x1000 arlen=3. 8 writes to consecutive dst words.
- len=5 → words=2, one burst with arlen=1. len=0 → no arvalid, done 2 cycles after start, error=0.
- len=16 with mem_ready low for 3 cycles on beat 2 → rready low in those cycles. Data and order are preserved and there are no duplicate writes.
- rresp=2'b10 on beat 1 of a 2-burst copy → beats 1..end of burst 0 are still written, no second arvalid, done with error=1. The next start with clean data clears error.
- reset asserted during beat 5 of 16 → next cycle busy=0, arvalid=0, rready=0, mem_wen=0. A fresh start completes normally.

Source files
------------

// File: rtl/axi4_spi_flash_boot_loader.sv
// Boot-time copy sequencer: reads a flash byte range over AXI4 INCR bursts and
// writes every returned beat to a word-wide memory write port.
module axi4_spi_flash_boot_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int MAX_BURST  = 16,
    parameter int LEN_WIDTH  = 24
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  length_bytes,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready
);

    localparam int CW = LEN_WIDTH - 1;
    localparam logic [CW-1:0] LP_MAX_BURST = CW'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]            r_arlen;
    logic [CW-1:0]         r_remaining;
    logic [8:0]            r_beats_left;
    logic                  r_error;

    logic [LEN_WIDTH:0]    w_len_round;
    logic [CW-1:0]         w_words;
    logic                  w_beat;
    logic                  w_last_beat;
    logic                  w_beat_err;
    logic [ADDR_WIDTH-1:0] w_src_inc;
    logic [CW-1:0]         w_rem_dec;
    logic [9:0]            w_calc_off;
    logic [CW-1:0]         w_calc_rem;
    logic [8:0]            w_beats;
    logic [7:0]            w_arlen;
    logic                  w_unused_ok;

    // Beats for the next burst: capped by remaining words, MAX_BURST and the
    // words left before the next 4 KB boundary.
    function automatic logic [8:0] burst_beats(input logic [9:0]    word_off,
                                               input logic [CW-1:0] rem);
        logic [CW-1:0] n;
        logic [CW-1:0] to_bound;
        to_bound = CW'(11'd1024 - {1'b0, word_off});
        n = rem;
        if (n > LP_MAX_BURST) n = LP_MAX_BURST;
        if (n > to_bound) n = to_bound;
        return n[8:0];
    endfunction

    assign w_len_round = {1'b0, length_bytes} + (LEN_WIDTH+1)'(3);
    assign w_words     = w_len_round[LEN_WIDTH:2];
    assign w_beat      = (r_state == S_DATA) && m_axi_rvalid && mem_ready;
    assign w_last_beat = w_beat && (r_beats_left == 9'd1);
    assign w_beat_err  = w_beat && ((m_axi_rresp != 2'b00) ||
                                    (m_axi_rlast != (r_beats_left == 9'd1)));
    assign w_src_inc   = r_src + ADDR_WIDTH'(4);
    assign w_rem_dec   = r_remaining - CW'(1);

    // In DATA the next burst is sized from the post-beat source and count.
    assign w_calc_off  = (r_state == S_INIT) ? r_src[11:2] : w_src_inc[11:2];
    assign w_calc_rem  = (r_state == S_INIT) ? r_remaining : w_rem_dec;
    assign w_beats     = burst_beats(w_calc_off, w_calc_rem);
    assign w_arlen     = 8'(w_beats - 9'd1);

    assign w_unused_ok = &{1'b0, m_axi_rid, src_addr[1:0], dst_addr[1:0], w_len_round[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
        w_state_next  = r_state;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        mem_wen       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_INIT;
            end
            S_INIT: begin
                w_state_next = (r_remaining == '0) ? S_DONE : S_ADDR;
            end
            S_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) w_state_next = S_DATA;
            end
            S_DATA: begin
                m_axi_rready = mem_ready;
                mem_wen      = m_axi_rvalid;
                if (w_last_beat) begin
                    if ((w_rem_dec != '0) && !r_error && !w_beat_err) begin
                        w_state_next = S_ADDR;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_src        <= '0;
            r_dst        <= '0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_remaining  <= '0;
            r_beats_left <= '0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src       <= {src_addr[ADDR_WIDTH-1:2], 2'b00};
                        r_dst       <= {dst_addr[ADDR_WIDTH-1:2], 2'b00};
                        r_remaining <= w_words;
                        r_error     <= 1'b0;
                    end
                end
                S_INIT: begin
                    if (r_remaining != '0) begin
                        r_araddr     <= r_src;
                        r_arlen      <= w_arlen;
                        r_beats_left <= w_beats;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        r_src        <= w_src_inc;
                        r_dst        <= r_dst + ADDR_WIDTH'(4);
                        r_remaining  <= w_rem_dec;
                        r_beats_left <= r_beats_left - 9'd1;
                        if (w_beat_err) r_error <= 1'b1;
                        if (w_last_beat) begin
                            r_araddr     <= w_src_inc;
                            r_arlen      <= w_arlen;
                            r_beats_left <= w_beats;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign error         = r_error;
    assign m_axi_arid    = '0;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0000;
    assign m_axi_arprot  = 3'b000;
    assign mem_addr      = r_dst;
    assign mem_wdata     = m_axi_rdata;

endmodule

// File: tb/tb_axi4_spi_flash_boot_loader.sv
// Scoreboard bench: a flash-slave model answers bursts with address+1 data;
// expected bursts and writes are queued at start and popped as the DUT emits them.
module tb_axi4_spi_flash_boot_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [23:0] length_bytes;
    logic        busy, done, error;
    logic [0:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [0:0]  m_axi_rid;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;

    axi4_spi_flash_boot_loader dut (
        .clock(clock), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length_bytes(length_bytes),
        .busy(busy), .done(done), .error(error),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] addr; logic [7:0]  len;  } ar_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

    ar_t exp_ar[$];
    wr_t exp_wr[$];

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;
    int beat_cnt = 0;
    int err_beat   = -1;
    int stall_beat = -1;

    // Flash slave model: one burst at a time, data = flash byte address + 1.
    initial begin
        logic        ar_hs, r_hs, rst_s;
        logic [31:0] ar_a, cur;
        logic [7:0]  ar_l;
        logic        active;
        int          left, stall_cycles;
        m_axi_arready = 1'b1;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        m_axi_rid     = '0;
        mem_ready     = 1'b1;
        active        = 1'b0;
        cur           = '0;
        left          = 0;
        stall_cycles  = 0;
        forever begin
            @(negedge clock);
            ar_hs = m_axi_arvalid && m_axi_arready;
            r_hs  = m_axi_rvalid && m_axi_rready;
            rst_s = reset;
            ar_a  = m_axi_araddr;
            ar_l  = m_axi_arlen;
            @(posedge clock);
            #1;
            if (rst_s) begin
                active = 1'b0;
                left   = 0;
            end else begin
                if (r_hs) begin
                    beat_cnt++;
                    cur = cur + 32'd4;
                    left--;
                    if (left == 0) active = 1'b0;
                end
                if (ar_hs) begin
                    active = 1'b1;
                    cur    = ar_a;
                    left   = int'(ar_l) + 1;
                end
            end
            m_axi_rvalid = active;
            m_axi_rdata  = cur + 32'd1;
            m_axi_rlast  = active && (left == 1);
            m_axi_rresp  = (active && beat_cnt == err_beat) ? 2'b10 : 2'b00;
            if (beat_cnt == stall_beat && stall_cycles < 3) begin
                mem_ready = 1'b0;
                stall_cycles++;
            end else begin
                mem_ready = 1'b1;
                if (beat_cnt != stall_beat) stall_cycles = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every AR handshake and accepted memory write.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (m_axi_arvalid && m_axi_arready) begin
                    ar_t e;
                    total++;
                    if (exp_ar.size() == 0) begin
                        bad++;
                        $display("FAIL ar_unexpected: got addr=%h len=%0d, required none", m_axi_araddr, m_axi_arlen);
                    end else begin
                        e = exp_ar.pop_front();
                        if ({m_axi_araddr, m_axi_arlen} !== {e.addr, e.len}) begin
                            bad++;
                            $display("FAIL ar_burst: got addr=%h len=%0d, required addr=%h len=%0d",
                                     m_axi_araddr, m_axi_arlen, e.addr, e.len);
                        end
                    end
                end
                if (mem_wen && mem_ready) begin
                    wr_t w;
                    total++;
                    if (exp_wr.size() == 0) begin
                        bad++;
                        $display("FAIL wr_unexpected: got addr=%h data=%h, required none", mem_addr, mem_wdata);
                    end else begin
                        w = exp_wr.pop_front();
                        if ({mem_addr, mem_wdata} !== {w.addr, w.data}) begin
                            bad++;
                            $display("FAIL mem_write: got addr=%h data=%h, required addr=%h data=%h",
                                     mem_addr, mem_wdata, w.addr, w.data);
                        end
                    end
                end
                if (!mem_ready) begin
                    total++;
                    if (m_axi_rready !== 1'b0) begin
                        bad++;
                        $display("FAIL rready_stall: got %b, required 0", m_axi_rready);
                    end
                end
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [23:0] len,
                            input int err_rel, input int stall_rel, input bit poke,
                            input logic exp_err, input string name);
        logic [31:0] sa, da;
        int words, rem, bt, idx, cycles, first_ar, last_wr, done_base;
        bit hit;
        sa    = s & ~32'd3;
        da    = d & ~32'd3;
        words = (int'(len) + 3) / 4;
        rem   = words;
        idx   = 0;
        hit   = 1'b0;
        while (rem > 0 && !hit) begin
            bt = rem;
            if (bt > 16) bt = 16;
            if (bt > (4096 - int'(sa[11:0])) / 4) bt = (4096 - int'(sa[11:0])) / 4;
            exp_ar.push_back('{addr: sa, len: 8'(bt - 1)});
            for (int i = 0; i < bt; i++) begin
                exp_wr.push_back('{addr: da, data: sa + 32'd1});
                if (idx == err_rel) hit = 1'b1;
                idx++;
                sa = sa + 32'd4;
                da = da + 32'd4;
            end
            rem -= bt;
        end
        err_beat   = (err_rel >= 0) ? beat_cnt + err_rel : -1;
        stall_beat = (stall_rel >= 0) ? beat_cnt + stall_rel : -1;
        done_base  = done_cnt;

        @(posedge clock); #1;
        src_addr = s; dst_addr = d; length_bytes = len; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;

        cycles = 0; first_ar = 0; last_wr = 0;
        do begin
            @(negedge clock);
            cycles++;
            if (cycles == 1) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s busy_after_start: got %b, required 1", name, busy);
                end
            end
            if (poke && cycles == 6) begin
                start = 1'b1; src_addr = 32'h0000_0400; length_bytes = 24'd4;
            end
            if (poke && cycles == 7) begin
                start = 1'b0; src_addr = s; length_bytes = len;
            end
            if (m_axi_arvalid && first_ar == 0) first_ar = cycles;
            if (mem_wen && mem_ready) last_wr = cycles;
        end while (!done && cycles < 3000);
        start = 1'b0;

        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s done_timeout: got no done after %0d cycles, required done", name, cycles);
        end else if (words > 0) begin
            total++;
            if (first_ar !== 2) begin
                bad++;
                $display("FAIL %s start_to_arvalid: got %0d cycles, required 2", name, first_ar);
            end
            if (cycles !== last_wr + 1) begin
                bad++;
                $display("FAIL %s last_beat_to_done: got %0d cycles, required 1", name, cycles - last_wr);
            end
        end else begin
            total++;
            if (cycles !== 2 || first_ar !== 0) begin
                bad++;
                $display("FAIL %s zero_len: got done at %0d arvalid at %0d, required done at 2 and no arvalid",
                         name, cycles, first_ar);
            end
        end
        total++;
        if (error !== exp_err) begin
            bad++;
            $display("FAIL %s error_flag: got %b, required %b", name, error, exp_err);
        end
        @(negedge clock);
        @(negedge clock);
        total++;
        if (done_cnt - done_base !== 1 || busy !== 1'b0 || error !== exp_err) begin
            bad++;
            $display("FAIL %s completion: got done_pulses=%0d busy=%b error=%b, required 1 0 %b",
                     name, done_cnt - done_base, busy, error, exp_err);
        end
        total++;
        if (exp_wr.size() != 0 || exp_ar.size() != 0) begin
            bad++;
            $display("FAIL %s missing_traffic: got %0d writes %0d bursts outstanding, required 0 0",
                     name, exp_wr.size(), exp_ar.size());
        end
        err_beat   = -1;
        stall_beat = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        src_addr = '0; dst_addr = '0; length_bytes = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++;
        if ({busy, done, error, m_axi_arvalid, m_axi_rready, mem_wen} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got busy/done/err/arv/rr/wen=%b, required 000000",
                     {busy, done, error, m_axi_arvalid, m_axi_rready, mem_wen});
        end
        total++;
        if ({m_axi_araddr, m_axi_arlen, mem_addr} !== 72'd0) begin
            bad++;
            $display("FAIL reset_addr: got araddr=%h arlen=%h mem_addr=%h, required 0",
                     m_axi_araddr, m_axi_arlen, mem_addr);
        end
        total++;
        if ({m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot}
            !== {1'b0, 3'b010, 2'b01, 1'b0, 4'b0000, 3'b000}) begin
            bad++;
            $display("FAIL ar_constants: got id=%b size=%b burst=%b lock=%b cache=%b prot=%b, required 0 010 01 0 0000 000",
                     m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot);
        end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_single_burst();
        run_copy(32'h0000_0000, 32'h8000_0000, 24'd64, -1, -1, 1'b0, 1'b0, "single_burst");
    endtask

    task automatic test_4k_boundary();
        run_copy(32'h0000_0FF0, 32'h8000_1000, 24'd32, -1, -1, 1'b0, 1'b0, "boundary");
    endtask

    task automatic test_odd_and_zero_length();
        run_copy(32'h0000_0103, 32'h8000_2002, 24'd5, -1, -1, 1'b0, 1'b0, "len5");
        run_copy(32'h0000_0200, 32'h8000_3000, 24'd0, -1, -1, 1'b0, 1'b0, "len0");
    endtask

    task automatic test_back_to_back();
        run_copy(32'h0000_0040, 32'h8000_4000, 24'd16, -1, 2, 1'b1, 1'b0, "stall_and_busy_start");
        run_copy(32'h0000_1FC0, 32'h8000_5000, 24'd200, -1, -1, 1'b0, 1'b0, "multi_burst");
    endtask

    task automatic test_error();
        run_copy(32'h0000_0FF0, 32'h8000_6000, 24'd32, 1, -1, 1'b0, 1'b1, "rresp_error");
        run_copy(32'h0000_0000, 32'h8000_7000, 24'd8, -1, -1, 1'b0, 1'b0, "error_cleared");
    endtask

    task automatic test_reset_mid();
        int base, n;
        base = beat_cnt;
        for (int i = 0; i < 16; i++) exp_wr.push_back('{addr: 32'h8000_8000 + 32'(i * 4), data: 32'(i * 4 + 1)});
        exp_ar.push_back('{addr: 32'h0, len: 8'd15});
        @(posedge clock); #1;
        src_addr = 32'h0; dst_addr = 32'h8000_8000; length_bytes = 24'd64; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        n = 0;
        while (beat_cnt < base + 5 && n < 200) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (beat_cnt < base + 5) begin
            bad++;
            $display("FAIL reset_mid_wait: got %0d beats, required 5", beat_cnt - base);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        total++;
        if ({busy, m_axi_arvalid, m_axi_rready, mem_wen} !== 4'b0) begin
            bad++;
            $display("FAIL reset_mid_state: got busy/arv/rr/wen=%b, required 0000",
                     {busy, m_axi_arvalid, m_axi_rready, mem_wen});
        end
        @(posedge clock); #1;
        reset = 1'b0;
        exp_wr.delete();
        exp_ar.delete();
        @(posedge clock);
        run_copy(32'h0000_0100, 32'h8000_9000, 24'd64, -1, -1, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_4k_boundary();
        test_odd_and_zero_length();
        test_back_to_back();
        test_error();
        test_reset_mid();
        repeat (3) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
